// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: byte codes, command and FSM encodings shared by the run controller
package cpu_run_ctrl_pkg;
    localparam logic [7:0] CH_CR   = 8'h0d;
    localparam logic [7:0] CH_LF   = 8'h0a;
    localparam logic [7:0] CH_G_LO = 8'h67;
    localparam logic [7:0] CH_G_UP = 8'h47;
    localparam logic [7:0] CH_Q_LO = 8'h71;
    localparam logic [7:0] CH_Q_UP = 8'h51;
    localparam logic [7:0] CH_B_LO = 8'h62;
    localparam logic [7:0] CH_B_UP = 8'h42;
    localparam logic [7:0] CH_C_LO = 8'h63;
    localparam logic [7:0] CH_C_UP = 8'h43;

    typedef enum logic [1:0] {S_IDLE, S_HEX, S_CR} state_t;
    typedef enum logic [1:0] {CMD_G, CMD_Q, CMD_B, CMD_C} cmd_t;

    typedef struct packed {
        logic ok;
        cmd_t cmd;
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.cmd = (b == CH_G_LO || b == CH_G_UP) ? CMD_G :
                (b == CH_Q_LO || b == CH_Q_UP) ? CMD_Q :
                (b == CH_B_LO || b == CH_B_UP) ? CMD_B : CMD_C;
        d.ok  = d.cmd != CMD_C || b == CH_C_LO || b == CH_C_UP;
        return d;
    endfunction
endpackage

// File: rtl/cpu_run_ctrl_hex_char_dec.sv
// hex_char_dec: ASCII byte to hex nibble, flags bytes that are not hex digits
module hex_char_dec (
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble
);
    logic dig, alpha;
    always_comb begin
        dig    = ch >= 8'h30 && ch <= 8'h39;
        alpha  = (ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46);
        is_hex = dig | alpha;
        nibble = dig ? ch[3:0] : alpha ? ch[3:0] + 4'd9 : 4'd0;
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: UART command parser driving cpu start/stop, start address and a PC breakpoint
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int         ADR_W   = 32,
    parameter logic [7:0] CR_CODE = CH_CR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_vld,
    input  logic [7:0]       rx_rdata,
    input  logic             stall,
    input  logic [ADR_W-1:0] pc,
    output logic             cpu_start,
    output logic             quit_cmd,
    output logic [ADR_W-1:0] start_adr,
    output logic             bp_hit,
    output logic             cmd_err
);
    localparam int ND = ADR_W / 4;
    localparam int CW = $clog2(ND + 1);

    state_t           state;
    cmd_t             cmd;
    cmd_dec_t         dec;
    logic [ADR_W-1:0] sh, bp_adr;
    logic [CW-1:0]    cnt;
    logic             bp_en, bp_armed, hit, is_hex;
    logic [3:0]       nibble;

    hex_char_dec u_hex (.ch(rx_rdata), .is_hex(is_hex), .nibble(nibble));

    assign dec = decode_cmd(rx_rdata);
    // armed re-opens only after the CPU has been stopped, so one pass over bp_adr fires once
    assign hit = bp_en & bp_armed & ~stall & (pc == bp_adr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd       <= CMD_G;
            sh        <= '0;
            cnt       <= '0;
            bp_adr    <= '0;
            bp_en     <= 1'b0;
            bp_armed  <= 1'b1;
            cpu_start <= 1'b0;
            quit_cmd  <= 1'b0;
            start_adr <= '0;
            bp_hit    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cpu_start <= 1'b0;
            quit_cmd  <= hit;
            cmd_err   <= 1'b0;
            bp_armed  <= stall | (bp_armed & ~hit);
            if (hit)
                bp_hit <= 1'b1;
            if (rx_vld) begin
                case (state)
                    S_IDLE: begin
                        if (dec.ok) begin
                            cmd   <= dec.cmd;
                            sh    <= '0;
                            cnt   <= '0;
                            state <= (dec.cmd == CMD_G || dec.cmd == CMD_B) ? S_HEX : S_CR;
                        end else if (rx_rdata != CR_CODE && rx_rdata != CH_LF) begin
                            cmd_err <= 1'b1;
                        end
                    end
                    S_HEX: begin
                        if (is_hex) begin
                            sh  <= {sh[ADR_W-5:0], nibble};
                            cnt <= cnt + CW'(1);
                            if (cnt == CW'(ND - 1))
                                state <= S_CR;
                        end else begin
                            cmd_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    S_CR: begin
                        state <= S_IDLE;
                        if (rx_rdata != CR_CODE) begin
                            cmd_err <= 1'b1;
                        end else begin
                            case (cmd)
                                CMD_G: begin
                                    if (stall) begin
                                        start_adr <= sh;
                                        cpu_start <= 1'b1;
                                        bp_hit    <= 1'b0;
                                    end else begin
                                        cmd_err <= 1'b1;
                                    end
                                end
                                CMD_Q: begin
                                    quit_cmd <= ~stall | hit;
                                    cmd_err  <= stall;
                                end
                                CMD_B: begin
                                    bp_adr <= sh;
                                    bp_en  <= 1'b1;
                                end
                                CMD_C: bp_en <= 1'b0;
                            endcase
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: vector table, directed corner sequences and random commands vs a command-level model
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_rdata = 8'h00;
    logic        stall = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        cpu_start, quit_cmd, bp_hit, cmd_err;
    logic [31:0] start_adr;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_quit = 0, n_err = 0, n_both = 0;

    cpu_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_rdata(rx_rdata),
        .stall(stall), .pc(pc), .cpu_start(cpu_start), .quit_cmd(quit_cmd),
        .start_adr(start_adr), .bp_hit(bp_hit), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_start <= n_start + int'(cpu_start);
        n_quit  <= n_quit + int'(quit_cmd);
        n_err   <= n_err + int'(cmd_err);
        n_both  <= n_both + int'(cpu_start & quit_cmd);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_vld = 1'b1;
        rx_rdata = b;
        @(negedge clk);
        rx_vld = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    typedef struct {
        logic        stall;
        int          st, qu, er;
        logic [31:0] adr;
    } vec_t;

    vec_t  vt[11];
    string vs[11];

    int bs, bq, be;
    task automatic base();
        #1;
        bs = n_start; bq = n_quit; be = n_err;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        string cr, s, hx;
        logic [31:0] m_adr, m_bp, v;
        logic m_bp_en;
        int kind, es, eq, ee, n;
        logic [7:0] l;
        cr = "\015";

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_start", cpu_start, 0);
        check("rst_quit", quit_cmd, 0);
        check("rst_adr", start_adr, 0);
        check("rst_bphit", bp_hit, 0);
        check("rst_err", cmd_err, 0);

        vt[0]  = '{1'b1, 1, 0, 0, 32'h0000abcd}; vs[0]  = {"g0000abcd", cr};
        vt[1]  = '{1'b0, 0, 0, 1, 32'h0000abcd}; vs[1]  = {"G12345678", cr};
        vt[2]  = '{1'b0, 0, 1, 0, 32'h0000abcd}; vs[2]  = {"Q", cr};
        vt[3]  = '{1'b1, 0, 0, 1, 32'h0000abcd}; vs[3]  = {"q", cr};
        vt[4]  = '{1'b1, 0, 0, 0, 32'h0000abcd}; vs[4]  = {"\012", cr};
        vt[5]  = '{1'b1, 0, 0, 1, 32'h0000abcd}; vs[5]  = "z";
        vt[6]  = '{1'b1, 0, 0, 1, 32'h0000abcd}; vs[6]  = {"g12", cr};
        vt[7]  = '{1'b1, 0, 0, 1, 32'h0000abcd}; vs[7]  = {"cx", cr};
        vt[8]  = '{1'b1, 0, 0, 0, 32'h0000abcd}; vs[8]  = {"B0000FFFF", cr};
        vt[9]  = '{1'b1, 0, 0, 0, 32'h0000abcd}; vs[9]  = {"C", cr};
        vt[10] = '{1'b1, 1, 0, 0, 32'hdeadbeef}; vs[10] = {"gDEADBEEF", cr};
        for (int i = 0; i < 11; i++) begin
            stall = vt[i].stall;
            base();
            send_str(vs[i]);
            settle();
            check($sformatf("vec%0d_start", i), n_start - bs, vt[i].st);
            check($sformatf("vec%0d_quit", i), n_quit - bq, vt[i].qu);
            check($sformatf("vec%0d_err", i), n_err - be, vt[i].er);
            check($sformatf("vec%0d_adr", i), start_adr, vt[i].adr);
        end

        // 1: start with exact timing
        stall = 1'b1;
        base();
        send_str({"g00000100", cr});
        check("t1_pulse", cpu_start, 1);
        check("t1_adr", start_adr, 32'h100);
        @(negedge clk);
        check("t1_pulse_end", cpu_start, 0);
        settle();
        check("t1_count", n_start - bs, 1);
        check("t1_err", n_err - be, 0);

        // 2: quit while running, then refused while stopped
        stall = 1'b0;
        base();
        send_str({"q", cr});
        check("t2_quit", quit_cmd, 1);
        settle();
        check("t2_quit_cnt", n_quit - bq, 1);
        stall = 1'b1;
        base();
        send_str({"q", cr});
        check("t2_err", cmd_err, 1);
        settle();
        check("t2_noquit", n_quit - bq, 0);

        // 3: breakpoint walk
        send_str({"b00000040", cr});
        base();
        pc = 32'h38;
        stall = 1'b0;
        for (int p = 32'h3c; p <= 32'h4c; p += 4) begin
            @(negedge clk);
            check($sformatf("t3_quit_%0h", p - 4), quit_cmd, (p == 32'h44) ? 1 : 0);
            pc = p;
        end
        settle();
        check("t3_quit_cnt", n_quit - bq, 1);
        check("t3_bphit", bp_hit, 1);
        stall = 1'b1;
        send_str({"g00000000", cr});
        check("t3_bphit_clr", bp_hit, 0);
        check("t3_start", cpu_start, 1);

        // 4: bad hex digit then a good command
        base();
        send_str("g0000x");
        check("t4_err_x", cmd_err, 1);
        send_str({"000", cr});
        stall = 1'b0;
        send_str({"q", cr});
        check("t4_quit", quit_cmd, 1);
        settle();
        check("t4_nostart", n_start - bs, 0);
        stall = 1'b1;

        // 5: reset mid-command
        send_str("g0000");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base();
        send_str({"c", cr});
        settle();
        check("t5_err", n_err - be, 0);
        check("t5_pulses", (n_start - bs) + (n_quit - bq), 0);
        check("t5_adr", start_adr, 0);
        check("t5_bphit", bp_hit, 0);

        // 6: breakpoint hit coincides with q execution
        send_str({"b00000200", cr});
        pc = 32'h0;
        stall = 1'b0;
        send_byte("q");
        base();
        @(negedge clk);
        rx_vld = 1'b1;
        rx_rdata = 8'h0d;
        pc = 32'h200;
        @(negedge clk);
        rx_vld = 1'b0;
        check("t6_quit", quit_cmd, 1);
        check("t6_bphit", bp_hit, 1);
        repeat (3) @(negedge clk);
        #1;
        check("t6_quit_cnt", n_quit - bq, 1);
        check("t6_err", n_err - be, 0);
        stall = 1'b1;
        send_str({"c", cr});

        // random commands against a command-level model
        pc = 32'hffffffff;
        m_adr = 32'h0;
        m_bp = 32'h0;
        m_bp_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            stall = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            l = (kind == 1 || kind == 5) ? 8'h71 : (kind == 3) ? 8'h63 :
                (kind == 2 || ($urandom_range(0, 1) == 1 && kind != 0)) ? 8'h62 : 8'h67;
            if (kind == 5 && $urandom_range(0, 1) == 1) l = 8'h63;
            if ($urandom_range(0, 1) == 1) l = l - 8'h20;
            v = $urandom;
            if (kind == 2) v[31] = 1'b0;
            hx = $sformatf("%08x", v);
            if ($urandom_range(0, 1) == 1) hx = hx.toupper();
            es = 0; eq = 0; ee = 0;
            case (kind)
                0: begin
                    s = {$sformatf("%c", l), hx, cr};
                    if (stall) begin es = 1; m_adr = v; end else ee = 1;
                end
                1: begin
                    s = {$sformatf("%c", l), cr};
                    if (stall) ee = 1; else eq = 1;
                end
                2: begin
                    s = {$sformatf("%c", l), hx, cr};
                    m_bp = v;
                    m_bp_en = 1'b1;
                end
                3: begin
                    s = {$sformatf("%c", l), cr};
                    m_bp_en = 1'b0;
                end
                6: begin
                    s = {"z", cr};
                    ee = 1;
                end
                default: begin
                    s = $sformatf("%c", l);
                    n = (kind == 5) ? 0 : $urandom_range(0, 7);
                    for (int k = 0; k < n; k++) s = {s, hx.substr(k, k)};
                    s = {s, (kind == 4) ? "" : "x", cr};
                    ee = 1;
                end
            endcase
            base();
            send_str(s);
            settle();
            check($sformatf("rnd%0d_start", i), n_start - bs, es);
            check($sformatf("rnd%0d_quit", i), n_quit - bq, eq);
            check($sformatf("rnd%0d_err", i), n_err - be, ee);
            check($sformatf("rnd%0d_adr", i), start_adr, m_adr);
        end

        // breakpoint state left by the random run
        stall = 1'b1;
        @(negedge clk);
        base();
        pc = m_bp;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rnd_bp_final", n_quit - bq, m_bp_en ? 1 : 0);
        stall = 1'b1;
        settle();
        check("exclusive", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
